// File: rtl/counter_chk_pkg.sv
// Shared types and reference arithmetic for the 4-bit enable counter checker.
// next_count/next_ovf encode the counter contract once so the on-chip model and
// any software-side predictor compute identical expectations. The functions
// work on a fixed FN_W-bit container; the w argument selects the live width.
package counter_chk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } chk_state_t;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned FN_W      = 16;

  function automatic logic [FN_W-1:0] width_mask(input int unsigned w);
    return FN_W'((32'd1 << w) - 32'd1);
  endfunction

  // count + en, modulo 2**w
  function automatic logic [FN_W-1:0] next_count(input logic [FN_W-1:0] cnt,
                                                 input logic            en,
                                                 input int unsigned     w = DEF_WIDTH);
    return (cnt + FN_W'(en)) & width_mask(w);
  endfunction

  // overflow pulses in the cycle the count lands on 0 after MAX
  function automatic logic next_ovf(input logic [FN_W-1:0] cnt,
                                    input logic            en,
                                    input int unsigned     w = DEF_WIDTH);
    return en && ((cnt & width_mask(w)) == width_mask(w));
  endfunction

endpackage

// File: rtl/counter_ref_model.sv
// Reference model of the enable counter used by counter_checker.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   load_i          reload from an observed sample (SYNC or resync after error)
//   load_count_i    observed count for the reload
//   load_en_i       observed enable accompanying load_count_i
//   dut_reset_i     observed counter reset: force count=0, ovf=0
//   advance_i       step the model one cycle using adv_en_i
//   adv_en_i        observed enable for the advance step
//   count_o, ovf_o  predicted count / overflow for the next compare
module counter_ref_model
  import counter_chk_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_count_i,
  input  logic             load_en_i,
  input  logic             dut_reset_i,
  input  logic             advance_i,
  input  logic             adv_en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [FN_W-1:0]  base;
  logic             base_en;

  // Load and advance share one step: the base is either the observed sample
  // or the model's own state.
  always_comb begin
    base    = load_i ? FN_W'(load_count_i) : FN_W'(count_q);
    base_en = load_i ? load_en_i : adv_en_i;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (dut_reset_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load_i || advance_i) begin
      count_d = WIDTH'(next_count(base, base_en, WIDTH));
      ovf_d   = next_ovf(base, base_en, WIDTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/counter_checker.sv
// Passive on-chip checker for the enable counter. Registers the monitored
// counter pins once, predicts them with counter_ref_model and reports
// mismatches.
// Ports:
//   clk, rst_n         clock (shared with the counter), async active-low reset
//   chk_en             1 = checking enabled, 0 = return to IDLE
//   clear_err          pulse: clear error status, capture and cycle count
//   mon_rst_n/enable/count/overflow  observed counter signals
//   in_sync            1 while in CHECK
//   err_flag           sticky mismatch flag
//   err_count          saturating mismatch count
//   first_exp/got      {ovf,count} expected/observed at first mismatch
//   chk_cycles         wrapping count of compared cycles
module counter_checker
  import counter_chk_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned ERR_W         = 8,
  parameter bit          RESYNC_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chk_en,
  input  logic             clear_err,
  input  logic             mon_rst_n,
  input  logic             mon_enable,
  input  logic [WIDTH-1:0] mon_count,
  input  logic             mon_overflow,
  output logic             in_sync,
  output logic             err_flag,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH:0]   first_exp,
  output logic [WIDTH:0]   first_got,
  output logic [15:0]      chk_cycles
);

  logic             s_rst_n_q, s_en_q, s_ovf_q;
  logic [WIDTH-1:0] s_count_q;

  chk_state_t state_q, state_d;

  logic             model_ovf;
  logic [WIDTH-1:0] model_count;
  logic             in_check, do_cmp, mismatch, model_load;

  logic             err_flag_q, err_flag_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [WIDTH:0]   first_exp_q, first_exp_d, first_got_q, first_got_d;
  logic [15:0]      chk_cycles_q, chk_cycles_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_rst_n_q <= 1'b0;
      s_en_q    <= 1'b0;
      s_ovf_q   <= 1'b0;
      s_count_q <= '0;
    end else begin
      s_rst_n_q <= mon_rst_n;
      s_en_q    <= mon_enable;
      s_ovf_q   <= mon_overflow;
      s_count_q <= mon_count;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!chk_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = SYNC;
        SYNC:    state_d = CHECK;
        CHECK:   state_d = CHECK;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign in_check   = (state_q == CHECK);
  // An observed counter reset suppresses the compare for that sample.
  assign do_cmp     = in_check && s_rst_n_q;
  assign mismatch   = do_cmp && ({s_ovf_q, s_count_q} != {model_ovf, model_count});
  assign model_load = (state_q == SYNC) || (RESYNC_ON_ERR && mismatch);

  counter_ref_model #(.WIDTH(WIDTH)) u_model (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (model_load),
    .load_count_i (s_count_q),
    .load_en_i    (s_en_q),
    .dut_reset_i  (in_check && !s_rst_n_q),
    .advance_i    (do_cmp),
    .adv_en_i     (s_en_q),
    .count_o      (model_count),
    .ovf_o        (model_ovf)
  );

  // clear_err takes priority: a mismatch in the clearing cycle is discarded.
  always_comb begin
    err_flag_d   = err_flag_q;
    err_count_d  = err_count_q;
    first_exp_d  = first_exp_q;
    first_got_d  = first_got_q;
    chk_cycles_d = chk_cycles_q;
    if (clear_err) begin
      err_flag_d   = 1'b0;
      err_count_d  = '0;
      first_exp_d  = '0;
      first_got_d  = '0;
      chk_cycles_d = '0;
    end else begin
      if (do_cmp) chk_cycles_d = chk_cycles_q + 16'd1;
      if (mismatch) begin
        err_flag_d = 1'b1;
        if (err_count_q != '1) err_count_d = err_count_q + ERR_W'(1);
        if (!err_flag_q) begin
          first_exp_d = {model_ovf, model_count};
          first_got_d = {s_ovf_q, s_count_q};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag_q   <= 1'b0;
      err_count_q  <= '0;
      first_exp_q  <= '0;
      first_got_q  <= '0;
      chk_cycles_q <= '0;
    end else begin
      err_flag_q   <= err_flag_d;
      err_count_q  <= err_count_d;
      first_exp_q  <= first_exp_d;
      first_got_q  <= first_got_d;
      chk_cycles_q <= chk_cycles_d;
    end
  end

  assign in_sync    = in_check;
  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;
  assign first_exp  = first_exp_q;
  assign first_got  = first_got_q;
  assign chk_cycles = chk_cycles_q;

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker: a behavioural counter drives the monitor
// pins, expected status values are queued with the cycle they become visible.
module tb_counter_checker;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n, chk_en, clear_err, mon_rst_n, mon_enable, mon_overflow;
  logic [W-1:0] mon_count;

  logic         in_sync, err_flag;
  logic [7:0]   err_count;
  logic [W:0]   first_exp, first_got;
  logic [15:0]  chk_cycles;

  logic         nr_in_sync, nr_err_flag;
  logic [7:0]   nr_err_count;
  logic [W:0]   nr_first_exp, nr_first_got;
  logic [15:0]  nr_chk_cycles;

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(W), .ERR_W(8), .RESYNC_ON_ERR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clear_err(clear_err),
    .mon_rst_n(mon_rst_n), .mon_enable(mon_enable), .mon_count(mon_count),
    .mon_overflow(mon_overflow), .in_sync(in_sync), .err_flag(err_flag),
    .err_count(err_count), .first_exp(first_exp), .first_got(first_got),
    .chk_cycles(chk_cycles)
  );

  counter_checker #(.WIDTH(W), .ERR_W(8), .RESYNC_ON_ERR(1'b0)) dut_nr (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clear_err(clear_err),
    .mon_rst_n(mon_rst_n), .mon_enable(mon_enable), .mon_count(mon_count),
    .mon_overflow(mon_overflow), .in_sync(nr_in_sync), .err_flag(nr_err_flag),
    .err_count(nr_err_count), .first_exp(nr_first_exp), .first_got(nr_first_got),
    .chk_cycles(nr_chk_cycles)
  );

  typedef enum int {K_SYNC, K_FLAG, K_ECNT, K_FEXP, K_FGOT, K_CYC,
                    K_NR_SYNC, K_NR_FLAG, K_NR_ECNT, K_NR_FEXP, K_NR_FGOT, K_NR_CYC} kind_t;
  typedef struct {
    string       tag;
    int          due;
    kind_t       kind;
    logic [31:0] val;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [W-1:0] cnt    = '0;
  logic         ovf    = 1'b0;
  bit           freeze = 1'b0;

  function automatic logic [31:0] observe(input kind_t k);
    case (k)
      K_SYNC:    return 32'(in_sync);
      K_FLAG:    return 32'(err_flag);
      K_ECNT:    return 32'(err_count);
      K_FEXP:    return 32'(first_exp);
      K_FGOT:    return 32'(first_got);
      K_CYC:     return 32'(chk_cycles);
      K_NR_SYNC: return 32'(nr_in_sync);
      K_NR_FLAG: return 32'(nr_err_flag);
      K_NR_ECNT: return 32'(nr_err_count);
      K_NR_FEXP: return 32'(nr_first_exp);
      K_NR_FGOT: return 32'(nr_first_got);
      default:   return 32'(nr_chk_cycles);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_at(input string tag, input int lat, input kind_t k, input logic [31:0] v);
    sb.push_back('{tag: tag, due: cyc + lat, kind: k, val: v});
  endtask

  // One clock: compare everything due now, then the counter takes its edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, observe(sb[i].kind), sb[i].val);
        sb.delete(i);
      end
    end
    if (!freeze) begin
      if (!mon_rst_n) begin
        cnt = '0;
        ovf = 1'b0;
      end else if (mon_enable) begin
        ovf = (cnt == '1);
        cnt = cnt + 1'b1;
      end else begin
        ovf = 1'b0;
      end
    end
    mon_count    = cnt;
    mon_overflow = ovf;
  endtask

  task automatic wait_count(input string tag, input logic [W-1:0] v);
    int n;
    n = 0;
    while (mon_count !== v && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $error("FAIL %s: counter never reached %0d within 40 cycles", tag, v);
    end
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  int cq, r;

  initial begin
    rst_n = 1'b0; chk_en = 1'b0; clear_err = 1'b0;
    mon_rst_n = 1'b1; mon_enable = 1'b0; mon_count = '0; mon_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_sync", 32'(in_sync), 32'd0);
    check("rst_err_flag", 32'(err_flag), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_first_exp", 32'(first_exp), 32'd0);
    check("rst_first_got", 32'(first_got), 32'd0);
    check("rst_chk_cycles", 32'(chk_cycles), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Clean run through several wraps
    mon_enable = 1'b1;
    chk_en     = 1'b1;
    expect_at("t1_sync_state", 1, K_SYNC, 0);
    expect_at("t1_in_sync", 2, K_SYNC, 1);
    expect_at("t1_cycles", 40, K_CYC, 38);
    expect_at("t1_flag", 40, K_FLAG, 0);
    expect_at("t1_nr_in_sync", 40, K_NR_SYNC, 1);
    expect_at("t1_nr_cycles", 40, K_NR_CYC, 38);
    repeat (40) tick();

    // Missing overflow pulse at wrap
    wait_count("t2_wait15", 4'd15);
    tick();
    mon_overflow = 1'b0;
    expect_at("t2_ecnt", 2, K_ECNT, 1);
    expect_at("t2_flag", 2, K_FLAG, 1);
    expect_at("t2_fexp", 2, K_FEXP, 32'h10);
    expect_at("t2_fgot", 2, K_FGOT, 32'h00);
    expect_at("t2_ecnt_hold", 6, K_ECNT, 1);
    repeat (6) tick();
    expect_at("clr_ecnt", 1, K_ECNT, 0);
    expect_at("clr_fexp", 1, K_FEXP, 0);
    expect_at("clr_nr_ecnt", 1, K_NR_ECNT, 0);
    pulse_clear();

    // Counter jumps 4 -> 7: one error with resync, one per cycle without
    wait_count("t3_wait5", 4'd5);
    cnt = 4'd7;
    mon_count = cnt;
    expect_at("t3_ecnt", 2, K_ECNT, 1);
    expect_at("t3_fexp", 2, K_FEXP, 32'h05);
    expect_at("t3_fgot", 2, K_FGOT, 32'h07);
    expect_at("t3_ecnt_hold", 6, K_ECNT, 1);
    expect_at("t3_nr_ecnt", 2, K_NR_ECNT, 1);
    expect_at("t3_nr_fexp", 2, K_NR_FEXP, 32'h05);
    expect_at("t3_nr_fgot", 2, K_NR_FGOT, 32'h07);
    expect_at("t3_nr_ecnt_grow", 6, K_NR_ECNT, 5);
    expect_at("t3_nr_flag", 6, K_NR_FLAG, 1);
    repeat (6) tick();
    pulse_clear();

    // Stuck counter: saturation of err_count
    wait_count("t4_wait3", 4'd3);
    freeze = 1'b1;
    expect_at("t4_ecnt_first", 3, K_ECNT, 1);
    expect_at("t4_fexp", 3, K_FEXP, 32'h04);
    expect_at("t4_fgot", 3, K_FGOT, 32'h03);
    expect_at("t4_ecnt_254", 256, K_ECNT, 254);
    expect_at("t4_ecnt_255", 257, K_ECNT, 255);
    expect_at("t4_ecnt_sat", 300, K_ECNT, 255);
    expect_at("t4_flag", 300, K_FLAG, 1);
    expect_at("t4_fexp_kept", 300, K_FEXP, 32'h04);
    expect_at("t4_fgot_kept", 300, K_FGOT, 32'h03);
    repeat (300) tick();

    // clear_err coincident with a mismatch
    clear_err = 1'b1;
    expect_at("t6_clr_ecnt", 1, K_ECNT, 0);
    expect_at("t6_clr_flag", 1, K_FLAG, 0);
    expect_at("t6_clr_fexp", 1, K_FEXP, 0);
    expect_at("t6_clr_cyc", 1, K_CYC, 0);
    tick();
    clear_err = 1'b0;
    expect_at("t6_recount", 1, K_ECNT, 1);
    expect_at("t6_recapture", 1, K_FEXP, 32'h04);
    tick();

    // Observed counter reset at 9
    freeze = 1'b0;
    repeat (3) tick();
    pulse_clear();
    cq = cyc;
    wait_count("t5_wait9", 4'd9);
    r = cyc;
    mon_rst_n = 1'b0;
    expect_at("t5_cyc_before", 1, K_CYC, 32'(r + 1 - cq));
    expect_at("t5_cyc_skip", 2, K_CYC, 32'(r + 1 - cq));
    expect_at("t5_cyc_after", 10, K_CYC, 32'(r + 9 - cq));
    expect_at("t5_ecnt", 10, K_ECNT, 0);
    expect_at("t5_flag", 10, K_FLAG, 0);
    tick();
    mon_rst_n = 1'b1;
    repeat (10) tick();

    // Spurious overflow pulse at count 6
    wait_count("t6_wait6", 4'd6);
    mon_overflow = 1'b1;
    expect_at("t6_extra_ecnt", 2, K_ECNT, 1);
    expect_at("t6_extra_fexp", 2, K_FEXP, 32'h06);
    expect_at("t6_extra_fgot", 2, K_FGOT, 32'h16);
    expect_at("t6_extra_hold", 4, K_ECNT, 1);
    repeat (4) tick();

    // Checking disabled: back to IDLE, status held
    chk_en = 1'b0;
    expect_at("t6_idle", 1, K_SYNC, 0);
    expect_at("t6_idle_hold", 2, K_ECNT, 1);
    repeat (2) tick();

    // Asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_sync", 32'(in_sync), 32'd0);
    check("arst_err_flag", 32'(err_flag), 32'd0);
    check("arst_err_count", 32'(err_count), 32'd0);
    check("arst_first_exp", 32'(first_exp), 32'd0);
    check("arst_first_got", 32'(first_got), 32'd0);
    check("arst_chk_cycles", 32'(chk_cycles), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $error("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
